// File: rtl/segmentos_pkg.sv
// Shared definitions for the 7-segment read-back path: code width, the
// active-low segment patterns of the display decoder, and the frame FSM states.
package segmentos_pkg;

  localparam int SEG_WIDTH = 7;

  // Segment order is g f e d c b a, a lit segment is 0
  localparam logic [SEG_WIDTH-1:0] SEG_0 = 7'b1000000;
  localparam logic [SEG_WIDTH-1:0] SEG_1 = 7'b1111001;
  localparam logic [SEG_WIDTH-1:0] SEG_2 = 7'b0100100;
  localparam logic [SEG_WIDTH-1:0] SEG_3 = 7'b0110000;
  localparam logic [SEG_WIDTH-1:0] SEG_4 = 7'b0011001;
  localparam logic [SEG_WIDTH-1:0] SEG_5 = 7'b0010010;
  localparam logic [SEG_WIDTH-1:0] SEG_6 = 7'b0000010;
  localparam logic [SEG_WIDTH-1:0] SEG_7 = 7'b1111000;
  localparam logic [SEG_WIDTH-1:0] SEG_8 = 7'b0000000;
  localparam logic [SEG_WIDTH-1:0] SEG_9 = 7'b0011000;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  // Largest value a frame of 'digits' decimal digits can carry (10^digits - 1)
  function automatic longint max_value(input int digits);
    longint p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return p - 1;
  endfunction

endpackage

// File: rtl/seg7_a_bcd.sv
// Combinational inverse of the 7-segment decoder: maps an active-low segment
// code to its BCD digit. Unknown patterns decode to 0 with valid low.
module seg7_a_bcd
  import segmentos_pkg::*;
(
  input  logic [SEG_WIDTH-1:0] seg_in,
  output logic [3:0]           digit,
  output logic                 valid
);

  // Table lookup; anything outside the ten digit patterns is flagged
  always_comb begin
    digit = 4'd0;
    valid = 1'b1;
    case (seg_in)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/segmentos_a_bin.sv
// Collects NUM_DIGITS active-low 7-segment codes (most significant first)
// under valid/ready, and reports the decimal value of the frame in binary
// with a one-cycle bin_valid pulse and a sticky-per-frame invalid-code flag.
module segmentos_a_bin
  import segmentos_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_WIDTH  = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 seg_valid,
  input  logic [6:0]           seg_in,
  output logic                 seg_ready,
  output logic [BIN_WIDTH-1:0] bin_out,
  output logic                 bin_valid,
  output logic                 error
);

  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 6) begin : g_bad_digits
    $error("segmentos_a_bin: NUM_DIGITS must be in 1..6");
  end
  if ((longint'(1) << BIN_WIDTH) <= max_value(NUM_DIGITS)) begin : g_bad_width
    $error("segmentos_a_bin: BIN_WIDTH too narrow for NUM_DIGITS decimal digits");
  end

  state_t               state;
  logic [BIN_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     count;
  logic                 err_acc;

  logic [SEG_WIDTH-1:0] seg_gated;
  logic [3:0]           digit;
  logic                 code_ok;
  logic                 transfer;
  logic [BIN_WIDTH-1:0] acc_next;
  logic [CNT_W-1:0]     count_next;
  logic                 err_next;

  // seg_in is forced to a known pattern when not valid so an undriven bus
  // can never reach the accumulator through the decoder
  assign seg_gated = seg_valid ? seg_in : SEG_0;

  seg7_a_bcd u_dec (
    .seg_in (seg_gated),
    .digit  (digit),
    .valid  (code_ok)
  );

  assign transfer   = seg_valid && seg_ready;
  // acc*10 + digit as two shifts and adds, wrapping at BIN_WIDTH
  assign acc_next   = (acc << 3) + (acc << 1) + BIN_WIDTH'(digit);
  assign count_next = count + CNT_W'(1);
  assign err_next   = err_acc | ~code_ok;

  // Frame FSM: accumulate digits in IDLE/COLLECT, publish result in DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      err_acc   <= 1'b0;
      seg_ready <= 1'b1;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      error     <= 1'b0;
    end else begin
      bin_valid <= 1'b0;
      case (state)
        IDLE, COLLECT: begin
          if (transfer) begin
            if (count_next == LAST_CNT) begin
              // Last digit: publish directly so bin_out is valid in DONE
              state     <= DONE;
              seg_ready <= 1'b0;
              bin_valid <= 1'b1;
              bin_out   <= acc_next;
              error     <= err_next;
              acc       <= '0;
              count     <= '0;
              err_acc   <= 1'b0;
            end else begin
              state   <= COLLECT;
              acc     <= acc_next;
              count   <= count_next;
              err_acc <= err_next;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          seg_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          seg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
